// File: rtl/mips_pkg.sv
// Shared types and constants for the simplified MIPS datapath.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_SLL = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SRL = 4'b0011;
  localparam alu_op_t ALU_SRA = 4'b0100;
  localparam alu_op_t ALU_AND = 4'b0101;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_XOR = 4'b0111;

  // Source of ALU operand 2
  typedef enum logic [1:0] {
    ImmRt    = 2'd0,
    ImmSext  = 2'd1,
    ImmZext  = 2'd2,
    ImmShamt = 2'd3
  } imm_sel_t;

  function automatic logic is_legal_op(input alu_op_t op);
    case (op)
      ALU_SLL, ALU_OR, ALU_ADD, ALU_SRL,
      ALU_SRA, ALU_AND, ALU_SUB, ALU_XOR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Issue, writeback, forward and ALU-side signals of the operand stage.
interface operand_stage_if;
  import mips_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rs;
  logic [REG_ADDR_W-1:0] in_rt;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [15:0]           in_imm;
  logic [1:0]            in_imm_sel;
  alu_op_t               in_alu_op;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;

  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;

  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_in1;
  logic [DATA_W-1:0]     out_in2;
  alu_op_t               out_alu_op;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0]     out_rt_data;
  logic                  out_illegal;

  // Decode side / environment
  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_imm_sel, in_alu_op,
    output wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, out_alu_op, out_rd, out_rt_data,
    input  out_illegal
  );

  // Operand stage
  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_imm_sel, in_alu_op,
    input  wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_in1, out_in2, out_alu_op, out_rd, out_rt_data,
    output out_illegal
  );

endinterface

// File: rtl/regfile.sv
// 32-entry register file: two combinational read ports, one write port, r0 reads as zero.
module regfile #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned RESET_REGS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [mips_pkg::REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]             rdata_a,
  input  logic [mips_pkg::REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]             rdata_b,
  input  logic                          we,
  input  logic [mips_pkg::REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]             wdata
);
  import mips_pkg::*;

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  if (RESET_REGS != 0) begin : g_reset
    // Storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
      end else if (wr_en) begin
        mem[waddr] <= wdata;
      end
    end
  end else begin : g_noreset
    // Storage without clear; contents undefined after reset
    always_ff @(posedge clk) begin
      if (wr_en) mem[waddr] <= wdata;
    end
  end

  // r0 is hardwired regardless of what the storage holds
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
  end

endmodule

// File: rtl/operand_stage.sv
// Register-read/issue stage: resolves operands and registers them for the ALU.
module operand_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned RESET_REGS = 1
) (
  input logic            clk,
  input logic            rst_n,
  operand_stage_if.slave bus
);
  import mips_pkg::*;

  logic [DATA_W-1:0]     rf_rs, rf_rt;
  logic [DATA_W-1:0]     rs_val, rt_val, in2_val;
  logic                  ready;
  logic                  load;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     in1_q, in2_q, rt_data_q;
  alu_op_t               alu_op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;

  regfile #(
    .DATA_W     (DATA_W),
    .NREGS      (NREGS),
    .RESET_REGS (RESET_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (bus.in_rs),
    .rdata_a (rf_rs),
    .raddr_b (bus.in_rt),
    .rdata_b (rf_rt),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data)
  );

  // EX forward beats same-cycle writeback, which beats the stored value
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0] a,
    input logic [DATA_W-1:0]     rf_val,
    input logic                  fwd_v,
    input logic [REG_ADDR_W-1:0] fwd_a,
    input logic [DATA_W-1:0]     fwd_d,
    input logic                  wb_v,
    input logic [REG_ADDR_W-1:0] wb_a,
    input logic [DATA_W-1:0]     wb_d
  );
    if (a == '0)                   return '0;
    else if (fwd_v && fwd_a == a)  return fwd_d;
    else if (wb_v && wb_a == a)    return wb_d;
    else                           return rf_val;
  endfunction

  // Operand resolution and operand-2 selection
  always_comb begin
    rs_val = resolve(bus.in_rs, rf_rs, bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                     bus.wb_en, bus.wb_addr, bus.wb_data);
    rt_val = resolve(bus.in_rt, rf_rt, bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                     bus.wb_en, bus.wb_addr, bus.wb_data);
    in2_val = rt_val;
    unique case (imm_sel_t'(bus.in_imm_sel))
      ImmRt:    in2_val = rt_val;
      ImmSext:  in2_val = {{16{bus.in_imm[15]}}, bus.in_imm};
      ImmZext:  in2_val = {16'b0, bus.in_imm};
      ImmShamt: in2_val = {27'b0, bus.in_imm[10:6]};
      default:  in2_val = rt_val;
    endcase
  end

  // Handshake and next valid; flush kills both the held and the offered entry
  always_comb begin
    ready = !valid_q || bus.out_ready;
    load  = bus.in_valid && ready && !bus.flush;
    if (bus.flush)  valid_d = 1'b0;
    else if (ready) valid_d = bus.in_valid;
    else            valid_d = valid_q;
  end

  // Valid bit (EMPTY/FULL)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Output payload register, loaded only on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_q     <= '0;
      in2_q     <= '0;
      rt_data_q <= '0;
      alu_op_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (load) begin
      in1_q     <= rs_val;
      in2_q     <= in2_val;
      rt_data_q <= rt_val;
      alu_op_q  <= bus.in_alu_op;
      rd_q      <= bus.in_rd;
      illegal_q <= !is_legal_op(bus.in_alu_op);
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_in1     = in1_q;
  assign bus.out_in2     = in2_q;
  assign bus.out_rt_data = rt_data_q;
  assign bus.out_alu_op  = alu_op_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with a behavioural reference model.
module tb_operand_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  operand_stage_if bus ();

  operand_stage #(
    .DATA_W     (32),
    .NREGS      (32),
    .RESET_REGS (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mregs [32];
  logic        exp_valid;
  logic [31:0] exp_in1, exp_in2, exp_rt;
  logic [3:0]  exp_op;
  logic [4:0]  exp_rd;
  logic        exp_ill;

  function automatic logic [31:0] m_res(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.fwd_valid && bus.fwd_rd == a) return bus.fwd_data;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return mregs[a];
  endfunction

  function automatic logic [31:0] m_in2(input logic [1:0] sel, input logic [15:0] imm,
                                        input logic [31:0] rt);
    case (sel)
      2'd0:    return rt;
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {16'd0, imm};
      default: return {27'd0, imm[10:6]};
    endcase
  endfunction

  function automatic logic m_ill(input logic [3:0] op);
    return op > 4'd7;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_in1 <= '0; exp_in2 <= '0; exp_rt <= '0; exp_op <= '0; exp_rd <= '0; exp_ill <= 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
    end else begin
      if (bus.flush) begin
        exp_valid <= 1'b0;
      end else if (!exp_valid || bus.out_ready) begin
        exp_valid <= bus.in_valid;
        if (bus.in_valid) begin
          exp_in1 <= m_res(bus.in_rs);
          exp_rt  <= m_res(bus.in_rt);
          exp_in2 <= m_in2(bus.in_imm_sel, bus.in_imm, m_res(bus.in_rt));
          exp_op  <= bus.in_alu_op;
          exp_rd  <= bus.in_rd;
          exp_ill <= m_ill(bus.in_alu_op);
        end
      end
      if (bus.wb_en && bus.wb_addr != 5'd0) mregs[bus.wb_addr] <= bus.wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    chk("in_ready", 32'(bus.in_ready), 32'(!exp_valid || bus.out_ready));
    if (exp_valid) begin
      chk("out_in1", bus.out_in1, exp_in1);
      chk("out_in2", bus.out_in2, exp_in2);
      chk("out_rt_data", bus.out_rt_data, exp_rt);
      chk("out_alu_op", 32'(bus.out_alu_op), 32'(exp_op));
      chk("out_rd", 32'(bus.out_rd), 32'(exp_rd));
      chk("out_illegal", 32'(bus.out_illegal), 32'(exp_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.fwd_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [1:0] sel, input logic [3:0] op);
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_imm = imm; bus.in_imm_sel = sel; bus.in_alu_op = op;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    quiet();
    bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_imm_sel = '0;
    bus.in_alu_op = '0; bus.wb_addr = '0; bus.wb_data = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    bus.out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_in1", bus.out_in1, 32'd0);
    tick();

    // Basic issue
    wb(5'd3, 32'h10); tick(); quiet();
    issue(5'd3, 5'd0, 5'd4, 16'hFFFC, 2'd1, ALU_ADD); tick(); quiet();
    chk("basic valid", 32'(bus.out_valid), 32'd1);
    chk("basic in1", bus.out_in1, 32'h10);
    chk("basic in2", bus.out_in2, 32'hFFFF_FFFC);
    chk("basic op", 32'(bus.out_alu_op), 32'h2);

    // Forward over writeback, then writeback bypass, then r0
    wb(5'd7, 32'h11); bus.fwd_valid = 1'b1; bus.fwd_rd = 5'd7; bus.fwd_data = 32'h22;
    issue(5'd7, 5'd0, 5'd1, 16'h0, 2'd0, ALU_OR); tick();
    chk("fwd prio", bus.out_in1, 32'h22);
    bus.fwd_valid = 1'b0; tick();
    chk("wb after fwd drop", bus.out_in1, 32'h11);
    wb(5'd9, 32'h33); issue(5'd9, 5'd9, 5'd1, 16'h0, 2'd0, ALU_SUB); tick();
    chk("wb bypass", bus.out_in1, 32'h33);
    chk("wb bypass rt", bus.out_in2, 32'h33);
    wb(5'd0, 32'hDEAD); issue(5'd0, 5'd0, 5'd1, 16'h0, 2'd0, ALU_XOR); tick();
    chk("r0 read", bus.out_in1, 32'h0);
    quiet(); issue(5'd0, 5'd0, 5'd1, 16'h0, 2'd0, ALU_AND); tick();
    chk("r0 not written", bus.out_in1, 32'h0);
    quiet(); tick();

    // Backpressure and back-to-back load
    issue(5'd3, 5'd0, 5'd10, 16'h0, 2'd0, ALU_ADD); tick();
    bus.out_ready = 1'b0;
    issue(5'd7, 5'd0, 5'd11, 16'h0, 2'd0, ALU_SRL);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall hold in1", bus.out_in1, 32'h10);
      chk("stall hold rd", 32'(bus.out_rd), 32'd10);
      tick();
    end
    bus.out_ready = 1'b1;
    tick(); quiet();
    chk("b2b valid", 32'(bus.out_valid), 32'd1);
    chk("b2b in1", bus.out_in1, 32'h11);
    chk("b2b rd", 32'(bus.out_rd), 32'd11);
    tick();

    // Flush with a simultaneous offer
    issue(5'd9, 5'd0, 5'd12, 16'h0, 2'd0, ALU_ADD); bus.flush = 1'b1; tick(); quiet();
    chk("flush valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("flush never appears", 32'(bus.out_valid), 32'd0);

    // Immediates and illegal code
    issue(5'd0, 5'd3, 5'd1, 16'h8001, 2'd2, ALU_SLL); tick();
    chk("zext imm", bus.out_in2, 32'h0000_8001);
    chk("rt data", bus.out_rt_data, 32'h10);
    issue(5'd0, 5'd0, 5'd1, 16'h07C0, 2'd3, ALU_SRA); tick();
    chk("shamt", bus.out_in2, 32'd31);
    issue(5'd0, 5'd0, 5'd1, 16'h0, 2'd0, 4'hF); tick(); quiet();
    chk("illegal flag", 32'(bus.out_illegal), 32'd1);
    chk("illegal passthru", 32'(bus.out_alu_op), 32'hF);

    // Asynchronous reset while an entry is held
    issue(5'd3, 5'd0, 5'd1, 16'h0, 2'd0, ALU_ADD); tick(); quiet();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in1", bus.out_in1, 32'd0);
    tick(); rst_n = 1'b1; tick();
    issue(5'd5, 5'd3, 5'd1, 16'h0, 2'd0, ALU_ADD); tick(); quiet();
    chk("r5 after reset", bus.out_in1, 32'd0);
    chk("r3 cleared", bus.out_in2, 32'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Register-read/issue stage directly upstream of the ALU in the simplified MIPS datapath.
- Holds the 32x32 register file and resolves forwarding and immediate selection.
- Registers the ALU operands (in1, in2) and the 4-bit ALU operation code in a single-entry valid/ready pipeline register, which the EX stage consumes.

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- NREGS, 32, register count; address width fixed at 5.
- RESET_REGS, 1, 1 = register file cleared on reset; 0 = contents undefined after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept.
- in_rs  in  5  source register for in1.
- in_rt  in  5  source register for in2 and store data.
- in_rd  in  5  destination register, passed through.
- in_imm  in  16  instruction immediate field.
- in_imm_sel  in  2  in2 source: 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = shamt (imm[10:6], zero-extended).
- in_alu_op  in  4  ALU operation code.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback register.
- wb_data  in  32  writeback value.
- fwd_valid  in  1  EX result forward valid.
- fwd_rd  in  5  EX destination register.
- fwd_data  in  32  EX result.
- flush  in  1  kill the registered entry and the entry being offered.
- out_valid  out  1  operands valid to ALU.
- out_ready  in  1  ALU stage accepts.
- out_in1  out  32  ALU operand 1.
- out_in2  out  32  ALU operand 2.
- out_alu_op  out  4  ALU operation code.
- out_rd  out  5  destination register.
- out_rt_data  out  32  resolved rt value (store data).
- out_illegal  out  1  in_alu_op is not a defined code.

Behaviour:
- Reset (rst_n low, asynchronous): all out_* = 0, out_valid = 0. Registers cleared if RESET_REGS = 1.
- in_ready = !out_valid || out_ready (combinational).
- Transfer: when in_valid && in_ready at a rising edge, the output register loads; out_valid = 1 next cycle. Latency is 1 cycle.
- Stall: while out_valid && !out_ready, all out_* are held stable.
- Operand resolution, per source address a, in priority order:
  - a == 0 gives 0.
  - fwd_valid && fwd_rd == a gives fwd_data.
  - wb_en && wb_addr == a gives wb_data (write-through bypass).
  - Otherwise the register file value.
- out_in1 = resolved rs.
- out_in2 is selected by in_imm_sel: resolved rt, {16{imm[15]}, imm}, {16'b0, imm}, or {27'b0, imm[10:6]}.
- out_rt_data = resolved rt, regardless of in_imm_sel.
- Writeback: wb_en && wb_addr != 0 writes at the rising edge. Writes to r0 are ignored. Writeback is independent of the handshake and of flush.
- Defined ALU codes: ADD 0010, SUB 0110, SLL 0000, SRL 0011, SRA 0100, OR 0001, AND 0101, XOR 0111.
  - Any other code: out_illegal = 1 and the code is passed through unchanged.
- flush: next cycle out_valid = 0. Any input transfer in the same cycle is discarded; flush wins. Output data fields may hold stale values.
- Reset mid-transfer: entry lost, out_valid = 0 immediately.
- No internal FSM beyond the valid bit. Two states: EMPTY and FULL.
  - EMPTY to FULL on accept.
  - FULL to EMPTY on out_ready && !in_valid, or on flush.
  - FULL stays FULL on simultaneous drain and accept.

Decomposition:
- Package mips_pkg holds:
  - ALU op code constants (ADD … XOR) and an alu_op_t typedef, 4 bits.
  - imm_sel_t enum.
  - REG_ADDR_W = 5 and DATA_W = 32.
- The ALU imports the same package.
- One sub-module, regfile: 32x32, two combinational read ports, one write port, r0 hardwired to 0, async active-low clear.
- Bypass, forwarding and the output register live in operand_stage.

Test Plan:
- Reset: assert rst_n = 0 mid-stream → out_valid = 0, out_in1 = 0 immediately; after release, reading r5 gives 0.
- Basic issue: write r3 = 0x0000_0010 via wb, then issue rs = 3, rt = 0, imm_sel = 1, imm = 0xFFFC, op = ADD → next cycle out_in1 = 0x10, out_in2 = 0xFFFF_FFFC, out_alu_op = 0010.
- Bypass and forward priority: same cycle set wb r7 = 0x11, fwd r7 = 0x22, issue rs = 7 → out_in1 = 0x22. Drop fwd → 0x11. wb to r0 = 0xDEAD, issue rs = 0 → 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held → in_ready = 0 and outputs stable. On out_ready = 1, next instruction loads in the same edge (back-to-back, no bubble).
- Flush: flush = 1 together with in_valid = 1 → next cycle out_valid = 0, and the entry never appears.
- Immediates and illegal code:
  - imm = 0x8001 with sel 2 → out_in2 = 0x0000_8001.
  - sel 3 with imm = 0x07C0 → out_in2 = 31.
  - op = 1111 → out_illegal = 1.
